// File: rtl/forward_hazard_unit_pkg.sv
// Shared constants for the forwarding/hazard unit: bypass select encodings and the hard-wired zero register.
package forward_hazard_unit_pkg;
  localparam logic [1:0] FW_REG   = 2'b00;
  localparam logic [1:0] FW_EXMEM = 2'b10;
  localparam logic [1:0] FW_MEMWB = 2'b01;
  localparam logic [1:0] FW_MD    = 2'b11;
  localparam int         ZERO_REG = 0;
endpackage

// File: rtl/md_scoreboard.sv
// Tracks in-flight fixed-latency mult/div ops: allocation, countdown, single-cycle writeback, full and sticky overflow.
// Result strobe appears MD_LAT-1 edges after the issue edge; issue while full is dropped.
module md_scoreboard
  import forward_hazard_unit_pkg::*;
#(
  parameter int AW       = 5,
  parameter int MD_LAT   = 4,
  parameter int SB_DEPTH = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   md_issue,
  input  logic [AW-1:0]          md_dest,
  output logic                   md_wb_valid,
  output logic [AW-1:0]          md_wb_addr,
  output logic                   sb_full,
  output logic                   sb_ovf,
  output logic [SB_DEPTH-1:0]    ent_vld,
  output logic [SB_DEPTH*AW-1:0] ent_addr,
  output logic [SB_DEPTH-1:0]    ent_busy
);
  localparam int            CW       = $clog2(MD_LAT);
  localparam logic [CW-1:0] CNT_INIT = CW'(MD_LAT - 1);

  logic [SB_DEPTH-1:0] vld_q, vld_d;
  logic [CW-1:0]       cnt_q  [SB_DEPTH];
  logic [CW-1:0]       cnt_d  [SB_DEPTH];
  logic [AW-1:0]       addr_q [SB_DEPTH];
  logic [AW-1:0]       addr_d [SB_DEPTH];
  logic                ovf_q, ovf_d;
  logic                alloc_done;

  assign sb_full = &vld_q;
  assign sb_ovf  = ovf_q;
  assign ent_vld = vld_q;

  always_comb begin
    md_wb_valid = 1'b0;
    md_wb_addr  = '0;
    ent_addr    = '0;
    ent_busy    = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      ent_addr[i*AW +: AW] = addr_q[i];
      ent_busy[i]          = vld_q[i] && (cnt_q[i] > CW'(1));
      // Fixed latency and one issue per cycle guarantee at most one entry at zero.
      if (vld_q[i] && cnt_q[i] == '0) begin
        md_wb_valid = 1'b1;
        md_wb_addr  = addr_q[i];
      end
    end
  end

  always_comb begin
    vld_d      = vld_q;
    ovf_d      = ovf_q | (md_issue & sb_full);
    alloc_done = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      cnt_d[i]  = cnt_q[i];
      addr_d[i] = addr_q[i];
      if (vld_q[i]) begin
        if (cnt_q[i] == '0) vld_d[i] = 1'b0;
        else                cnt_d[i] = cnt_q[i] - CW'(1);
      end
    end
    // Freeing happens at this edge, so a retiring entry is not reusable until the next cycle.
    if (md_issue && !sb_full && md_dest != AW'(ZERO_REG)) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        if (!alloc_done && !vld_q[i]) begin
          vld_d[i]   = 1'b1;
          cnt_d[i]   = CNT_INIT;
          addr_d[i]  = md_dest;
          alloc_done = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= '0;
      ovf_q <= 1'b0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        cnt_q[i]  <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      ovf_q <= ovf_d;
      for (int i = 0; i < SB_DEPTH; i++) begin
        cnt_q[i]  <= cnt_d[i];
        addr_q[i] <= addr_d[i];
      end
    end
  end
endmodule

// File: rtl/forward_hazard_unit.sv
// EX-stage bypass selects, ID-stage load-use / multicycle RAW stall, and a saturating stall-cycle counter.
// fw_sel and stall are combinational; stall_cnt updates at the edge.
module forward_hazard_unit
  import forward_hazard_unit_pkg::*;
#(
  parameter int AW       = 5,
  parameter int NSRC     = 2,
  parameter int MD_LAT   = 4,
  parameter int SB_DEPTH = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 reg_f4,
  input  logic                 reg_f5,
  input  logic [AW-1:0]        escrita_f4,
  input  logic [AW-1:0]        escrita_f5,
  input  logic [NSRC*AW-1:0]   src_f3,
  input  logic [NSRC*AW-1:0]   src_f2,
  input  logic                 load_f3,
  input  logic [AW-1:0]        dest_f3,
  input  logic                 md_issue,
  input  logic [AW-1:0]        md_dest,
  output logic [2*NSRC-1:0]    fw_sel,
  output logic                 stall,
  output logic                 md_wb_valid,
  output logic [AW-1:0]        md_wb_addr,
  output logic                 sb_full,
  output logic                 sb_ovf,
  output logic [15:0]          stall_cnt
);
  logic [SB_DEPTH-1:0]    ent_vld;
  logic [SB_DEPTH*AW-1:0] ent_addr;
  logic [SB_DEPTH-1:0]    ent_busy;
  logic [15:0]            stall_cnt_q, stall_cnt_d;

  md_scoreboard #(
    .AW       (AW),
    .MD_LAT   (MD_LAT),
    .SB_DEPTH (SB_DEPTH)
  ) u_sb (
    .clock       (clock),
    .reset       (reset),
    .md_issue    (md_issue),
    .md_dest     (md_dest),
    .md_wb_valid (md_wb_valid),
    .md_wb_addr  (md_wb_addr),
    .sb_full     (sb_full),
    .sb_ovf      (sb_ovf),
    .ent_vld     (ent_vld),
    .ent_addr    (ent_addr),
    .ent_busy    (ent_busy)
  );

  always_comb begin
    fw_sel = '0;
    for (int i = 0; i < NSRC; i++) begin
      fw_sel[2*i +: 2] = FW_REG;
      if (src_f3[i*AW +: AW] != AW'(ZERO_REG)) begin
        if (reg_f4 && escrita_f4 == src_f3[i*AW +: AW])
          fw_sel[2*i +: 2] = FW_EXMEM;
        else if (md_wb_valid && md_wb_addr == src_f3[i*AW +: AW])
          fw_sel[2*i +: 2] = FW_MD;
        else if (reg_f5 && escrita_f5 == src_f3[i*AW +: AW])
          fw_sel[2*i +: 2] = FW_MEMWB;
      end
    end
  end

  // An entry at count 1 retires next cycle, just in time for the consumer's EX bypass.
  always_comb begin
    stall = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (src_f2[i*AW +: AW] != AW'(ZERO_REG)) begin
        if (load_f3 && dest_f3 == src_f2[i*AW +: AW]) stall = 1'b1;
        for (int j = 0; j < SB_DEPTH; j++) begin
          if (ent_vld[j] && ent_busy[j] && ent_addr[j*AW +: AW] == src_f2[i*AW +: AW])
            stall = 1'b1;
        end
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed and random checks of forward_hazard_unit against a pending-op list model keyed on writeback cycle.
module tb_forward_hazard_unit;
  localparam int AW = 5, NSRC = 2, MD_LAT = 4, SB_DEPTH = 2;

  logic                clock = 1'b0;
  logic                reset;
  logic                reg_f4, reg_f5;
  logic [AW-1:0]       escrita_f4, escrita_f5;
  logic [NSRC*AW-1:0]  src_f3, src_f2;
  logic                load_f3;
  logic [AW-1:0]       dest_f3;
  logic                md_issue;
  logic [AW-1:0]       md_dest;
  logic [2*NSRC-1:0]   fw_sel;
  logic                stall, md_wb_valid, sb_full, sb_ovf;
  logic [AW-1:0]       md_wb_addr;
  logic [15:0]         stall_cnt;

  always #5 clock = ~clock;

  forward_hazard_unit #(.AW(AW), .NSRC(NSRC), .MD_LAT(MD_LAT), .SB_DEPTH(SB_DEPTH)) dut (
    .clock(clock), .reset(reset), .reg_f4(reg_f4), .reg_f5(reg_f5),
    .escrita_f4(escrita_f4), .escrita_f5(escrita_f5), .src_f3(src_f3), .src_f2(src_f2),
    .load_f3(load_f3), .dest_f3(dest_f3), .md_issue(md_issue), .md_dest(md_dest),
    .fw_sel(fw_sel), .stall(stall), .md_wb_valid(md_wb_valid), .md_wb_addr(md_wb_addr),
    .sb_full(sb_full), .sb_ovf(sb_ovf), .stall_cnt(stall_cnt)
  );

  int n_assert = 0, n_fail = 0;

  // Model: each pending op is remembered by the cycle in which its result writes back.
  typedef struct { logic [AW-1:0] addr; int wb_cyc; } op_t;
  op_t pend[$];
  int  cyc = 0;
  logic m_ovf = 1'b0;
  int  m_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_wbv();
    foreach (pend[k]) if (pend[k].wb_cyc == cyc) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [AW-1:0] m_wba();
    foreach (pend[k]) if (pend[k].wb_cyc == cyc) return pend[k].addr;
    return '0;
  endfunction

  function automatic logic [2*NSRC-1:0] m_fw();
    logic [2*NSRC-1:0] r = '0;
    for (int i = 0; i < NSRC; i++) begin
      logic [AW-1:0] s = src_f3[i*AW +: AW];
      if (s == 0)                              r[2*i +: 2] = 2'b00;
      else if (reg_f4 && escrita_f4 == s)      r[2*i +: 2] = 2'b10;
      else if (m_wbv() && m_wba() == s)        r[2*i +: 2] = 2'b11;
      else if (reg_f5 && escrita_f5 == s)      r[2*i +: 2] = 2'b01;
    end
    return r;
  endfunction

  function automatic logic m_stall();
    for (int i = 0; i < NSRC; i++) begin
      logic [AW-1:0] s = src_f2[i*AW +: AW];
      if (s != 0) begin
        if (load_f3 && dest_f3 == s) return 1'b1;
        foreach (pend[k]) if (pend[k].addr == s && pend[k].wb_cyc - cyc > 1) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic logic m_full();
    return pend.size() == SB_DEPTH;
  endfunction

  task automatic model_edge();
    logic st, fl;
    st = m_stall();
    fl = m_full();
    cyc++;
    if (reset) begin
      pend.delete();
      m_ovf = 1'b0;
      m_cnt = 0;
      return;
    end
    for (int k = pend.size() - 1; k >= 0; k--) if (pend[k].wb_cyc < cyc) pend.delete(k);
    if (md_issue) begin
      if (fl) m_ovf = 1'b1;
      else if (md_dest != 0) pend.push_back('{md_dest, cyc + MD_LAT - 1});
    end
    if (st && m_cnt < 65535) m_cnt++;
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".fw_sel"}, 32'(fw_sel), 32'(m_fw()));
    chk({ctx, ".stall"}, 32'(stall), 32'(m_stall()));
    chk({ctx, ".md_wb_valid"}, 32'(md_wb_valid), 32'(m_wbv()));
    chk({ctx, ".md_wb_addr"}, 32'(md_wb_addr), 32'(m_wba()));
    chk({ctx, ".sb_full"}, 32'(sb_full), 32'(m_full()));
    chk({ctx, ".sb_ovf"}, 32'(sb_ovf), 32'(m_ovf));
    chk({ctx, ".stall_cnt"}, 32'(stall_cnt), 32'(m_cnt));
  endtask

  task automatic idle_inputs();
    reg_f4 = 0; reg_f5 = 0; escrita_f4 = 0; escrita_f5 = 0;
    src_f3 = 0; src_f2 = 0; load_f3 = 0; dest_f3 = 0; md_issue = 0; md_dest = 0;
  endtask

  initial begin
    int wb_seen;
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    @(negedge clock);
    chk("rst.sb_full", 32'(sb_full), 0);
    chk("rst.sb_ovf", 32'(sb_ovf), 0);
    chk("rst.stall_cnt", 32'(stall_cnt), 0);
    chk("rst.md_wb_valid", 32'(md_wb_valid), 0);
    check_all("rst");
    tick();

    // Forwarding priority
    reg_f4 = 1; escrita_f4 = 8; reg_f5 = 1; escrita_f5 = 8;
    src_f3[0 +: AW] = 8; src_f3[AW +: AW] = 8;
    @(negedge clock);
    chk("fwd.exmem", 32'(fw_sel), 32'h0000000a);
    escrita_f4 = 0;
    #1;
    chk("fwd.memwb", 32'(fw_sel), 32'h00000005);
    check_all("fwd");
    tick();

    // Zero register never matches
    reg_f4 = 1; reg_f5 = 1; escrita_f4 = 0; escrita_f5 = 0;
    src_f3 = 0; src_f2 = 0; load_f3 = 1; dest_f3 = 0;
    @(negedge clock);
    chk("zero.fw_sel", 32'(fw_sel), 0);
    chk("zero.stall", 32'(stall), 0);
    tick();

    // Load-use
    idle_inputs();
    load_f3 = 1; dest_f3 = 5; src_f2[AW +: AW] = 5;
    @(negedge clock);
    chk("lu.stall", 32'(stall), 1);
    tick();
    idle_inputs();
    @(negedge clock);
    chk("lu.stall_after", 32'(stall), 0);
    chk("lu.stall_cnt", 32'(stall_cnt), 1);
    check_all("lu");
    tick();

    // Multicycle RAW
    md_issue = 1; md_dest = 9;
    @(negedge clock);
    check_all("md.issue");
    tick();
    md_issue = 0; md_dest = 0; src_f2[0 +: AW] = 9;
    @(negedge clock); chk("md.stall_e0", 32'(stall), 1); check_all("md.e0");
    tick();
    @(negedge clock); chk("md.stall_e1", 32'(stall), 1); check_all("md.e1");
    tick();
    @(negedge clock); chk("md.stall_e2", 32'(stall), 0); check_all("md.e2");
    tick();
    src_f2 = 0; src_f3[0 +: AW] = 9;
    @(negedge clock);
    chk("md.wb_valid", 32'(md_wb_valid), 1);
    chk("md.wb_addr", 32'(md_wb_addr), 9);
    chk("md.fw_sel0", 32'(fw_sel[1:0]), 3);
    check_all("md.e3");
    tick();
    idle_inputs();

    // Full / overflow
    md_issue = 1; md_dest = 3;
    @(negedge clock); chk("full.first", 32'(sb_full), 0);
    tick();
    md_dest = 4;
    @(negedge clock); chk("full.second", 32'(sb_full), 0);
    tick();
    md_dest = 6;
    @(negedge clock); chk("full.after2", 32'(sb_full), 1); check_all("full");
    tick();
    md_issue = 0; md_dest = 0;
    wb_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (c == 0) chk("full.ovf", 32'(sb_ovf), 1);
      if (md_wb_valid === 1'b1) wb_seen++;
      check_all("full.drain");
      tick();
    end
    chk("full.wb_count", 32'(wb_seen), 2);

    // Reset mid-operation
    md_issue = 1; md_dest = 10;
    @(negedge clock); tick();
    md_dest = 11;
    @(negedge clock); tick();
    md_issue = 0; md_dest = 0; reset = 1;
    @(negedge clock); tick();
    reset = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      chk("rstmid.wb_valid", 32'(md_wb_valid), 0);
      if (c == 0) begin
        chk("rstmid.sb_full", 32'(sb_full), 0);
        chk("rstmid.sb_ovf", 32'(sb_ovf), 0);
        chk("rstmid.stall_cnt", 32'(stall_cnt), 0);
      end
      tick();
    end

    // Random traffic against the model
    for (int c = 0; c < 800; c++) begin
      reset      = ($urandom_range(0, 99) == 0);
      reg_f4     = $urandom_range(0, 1);
      reg_f5     = $urandom_range(0, 1);
      escrita_f4 = AW'($urandom_range(0, 7));
      escrita_f5 = AW'($urandom_range(0, 7));
      for (int i = 0; i < NSRC; i++) begin
        src_f3[i*AW +: AW] = AW'($urandom_range(0, 7));
        src_f2[i*AW +: AW] = AW'($urandom_range(0, 7));
      end
      load_f3  = ($urandom_range(0, 3) == 0);
      dest_f3  = AW'($urandom_range(0, 7));
      md_issue = ($urandom_range(0, 2) == 0);
      md_dest  = AW'($urandom_range(0, 7));
      @(negedge clock);
      check_all("rand");
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/forward_hazard_unit.md
# forward_hazard_unit

Parametrised forwarding and hazard unit for the pipelined MIPS32 core. It generates per-source bypass selects for the EX stage (phase 3) from the EX/MEM (phase 4), MEM/WB (phase 5) and multicycle-unit result paths. It detects load-use and multicycle RAW hazards against the ID stage (phase 2) and stalls the front end. A scoreboard tracks outstanding fixed-latency multicycle operations (mult/div), and a stall-cycle performance counter is included.

## Interface
- `AW`, 5: register address width.
- `NSRC`, 2: source operands per instruction.
- `MD_LAT`, 4: multicycle result latency in cycles; must be 2 or more.
- `SB_DEPTH`, 2: number of outstanding multicycle operations tracked.
- `clock`  in  1  sole clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `reg_f4`, `reg_f5`  in  1 each  register-write enables for phase 4 and phase 5.
- `escrita_f4`, `escrita_f5`  in  AW each  destination registers for phase 4 and phase 5.
- `src_f3`  in  NSRC*AW  EX-stage source registers; source i occupies `[i*AW +: AW]`.
- `src_f2`  in  NSRC*AW  ID-stage source registers, same packing.
- `load_f3`  in  1  EX instruction is a load.
- `dest_f3`  in  AW  EX destination register.
- `md_issue`  in  1  a multicycle op leaves EX this cycle.
- `md_dest`  in  AW  its destination register.
- `fw_sel`  out  2*NSRC  per-source select: 00 register file, 10 EX/MEM, 01 MEM/WB, 11 multicycle result.
- `stall`  out  1  freeze PC and IF/ID; inject a bubble into ID/EX.
- `md_wb_valid`  out  1  multicycle result writes back this cycle.
- `md_wb_addr`  out  AW  its destination register.
- `sb_full`  out  1  all scoreboard entries valid.
- `sb_ovf`  out  1  sticky: `md_issue` arrived while full.
- `stall_cnt`  out  16  saturating count of stall cycles.

## Operation
- **Forwarding** (combinational, per source i). Let s = `src_f3[i]`. Register 0 never matches. Every path is fully assigned, so no latches. Priority is highest first:
  - 10 when `reg_f4` is set and `escrita_f4` == s.
  - 11 when `md_wb_valid` is set and `md_wb_addr` == s.
  - 01 when `reg_f5` is set and `escrita_f5` == s.
  - 00 otherwise.
- **Scoreboard.** SB_DEPTH entries, each holding {valid, addr, count}.
  - On `md_issue` && !`sb_full`: the lowest free entry is loaded with count = MD_LAT-1 and addr = `md_dest`.
  - Valid entries decrement their count each cycle.
  - An entry with count == 0 drives `md_wb_valid`/`md_wb_addr` and is freed at the next edge.
  - At most one entry can reach 0 per cycle, because issue is limited to one per cycle and latency is fixed.
  - `md_dest` == 0 allocates nothing.
- **Full / overflow.** `sb_full` is computed from current state only. A retirement in the same cycle does not make room. `md_issue` while full is dropped and sets `sb_ovf`, which stays set until reset.
- **Stall** (combinational). `stall` = 1 if any nonzero `src_f2[i]` meets either condition:
  - Load-use: `load_f3` is set and `dest_f3` == `src_f2[i]`.
  - Multicycle RAW: the register matches a valid entry with count > 1.
  
  With count == 1 the instruction proceeds and receives select 11 in EX.
- **Counter.** `stall_cnt` increments on each cycle with `stall` = 1 and saturates at 16'hFFFF.

## Timing
- `fw_sel`, `stall`, `sb_full` are zero-latency combinational outputs.
- Issue sampled at edge 0 → `md_wb_valid` is high for exactly one cycle, MD_LAT-1 edges later. The entry is free after the following edge.
- A load-use stall lasts exactly 1 cycle.
- A multicycle RAW stall lasts until the entry's count reaches 1.
- Reset (including mid-operation) clears all entries, `sb_ovf` and `stall_cnt` at the edge. All outputs read 0 in the following cycle.

## Structure
- Shared package holds:
  - `FW_REG` = 2'b00, `FW_EXMEM` = 2'b10, `FW_MEMWB` = 2'b01, `FW_MD` = 2'b11.
  - `ZERO_REG` = 0.
- Sub-module `md_scoreboard` (params AW, MD_LAT, SB_DEPTH) owns allocation, countdown, retire, `sb_full` and `sb_ovf`. It exports per-entry valid, addr and "count>1" vectors.
- The top level holds the forwarding muxes, the stall logic and `stall_cnt`.

## Test plan
- Forwarding priority: `reg_f4` = 1, `escrita_f4` = 8; `reg_f5` = 1, `escrita_f5` = 8; `src_f3` = {8, 8} → `fw_sel` = 4'b1010. Change `escrita_f4` to 0 → `fw_sel` = 4'b0101.
- Zero register: all write enables set, all addresses and sources = 0 → `fw_sel` = 0 and `stall` = 0.
- Load-use: `load_f3` = 1, `dest_f3` = 5, `src_f2[1]` = 5 for one cycle → `stall` = 1 for one cycle and `stall_cnt` = 1.
- Multicycle RAW with MD_LAT = 4: issue `md_dest` = 9 at edge 0, then hold `src_f2[0]` = 9.
  - `stall` = 1 after edges 0 and 1 (count 3, then 2), and 0 after edge 2 (count 1).
  - After edge 3: `md_wb_valid` = 1, `md_wb_addr` = 9, and `src_f3[0]` = 9 gives select 11.
- Full / overflow with SB_DEPTH = 2: issue on 3 consecutive cycles → `sb_full` = 1 after the second; the third is dropped, `sb_ovf` = 1, and only 2 writebacks occur.
- Reset mid-operation: assert `reset` with 2 entries pending → after the edge, `md_wb_valid` never rises, and `sb_full`, `sb_ovf`, `stall_cnt` all read 0.
